// File: rtl/onehot_decoder_seq_pkg.sv
// Shared definitions for the one-hot decoder/scan sequencer: mode encodings
// and a width helper for the prescaler.
package onehot_decoder_seq_pkg;

    typedef enum logic [1:0] {
        MODE_HOLD    = 2'b00,
        MODE_LOAD    = 2'b01,
        MODE_SCAN_UP = 2'b10,
        MODE_SCAN_DN = 2'b11
    } mode_t;

    // Bits needed to count 0..v-1, never less than one.
    function automatic int clog2_min1(input int v);
        int r;
        r = 0;
        while ((1 << r) < v) r++;
        return (r < 1) ? 1 : r;
    endfunction

endpackage

// File: rtl/onehot_decoder_seq_if.sv
// Control and status bundle of the decoder; the master drives en/mode/a,
// the slave (the decoder) returns the registered decode and its status.
interface onehot_decoder_seq_if #(parameter int N = 3);
    import onehot_decoder_seq_pkg::*;

    // valid is a status qualifier (idx is defined), not a handshake: there is
    // no ready, and en/mode/a are sampled on every rising clock edge.
    logic              en;
    mode_t             mode;
    logic [N-1:0]      a;
    logic [2**N-1:0]   out;
    logic [N-1:0]      idx;
    logic              valid;
    logic              wrap;

    modport master (output en, mode, a, input out, idx, valid, wrap);
    modport slave  (input en, mode, a, output out, idx, valid, wrap);

endinterface

// File: rtl/onehot_decoder_seq_dec.sv
// Plain N-to-2^N one-hot decode; polarity and valid gating live in the parent.
module onehot_dec #(
    parameter int N = 3
) (
    input  logic [N-1:0]    sel,
    output logic [2**N-1:0] dec
);
    localparam int OUT_W = 2**N;

    assign dec = OUT_W'(1) << sel;

endmodule

// File: rtl/onehot_decoder_seq.sv
// Registered one-hot decoder with load/hold and prescaled up/down scanning;
// out is derived only from the registered idx/valid.
module onehot_decoder_seq
    import onehot_decoder_seq_pkg::*;
#(
    parameter int N          = 3,
    parameter int DIV        = 4,
    parameter int ACTIVE_LOW = 0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    onehot_decoder_seq_if.slave   bus
);
    localparam int OUT_W = 2**N;
    localparam int PW    = clog2_min1(DIV);
    localparam logic [OUT_W-1:0] POL = (ACTIVE_LOW != 0) ? {OUT_W{1'b1}} : {OUT_W{1'b0}};

    if (N < 1 || N > 6 || DIV < 1) begin : g_bad_param
        $fatal(1, "onehot_decoder_seq: N must be 1..6 and DIV >= 1");
    end

    logic [N-1:0]  idx_q;
    logic          valid_q;
    logic          wrap_q;
    logic [PW-1:0] presc_q;
    mode_t         last_mode_q;

    logic          scan_up;
    logic          step_due;
    logic          at_edge;
    logic [N-1:0]  idx_step;
    logic [OUT_W-1:0] dec;

    always_comb begin
        scan_up  = (bus.mode == MODE_SCAN_UP);
        step_due = (presc_q == PW'(DIV - 1));
        idx_step = scan_up ? (idx_q + N'(1)) : (idx_q - N'(1));
        at_edge  = scan_up ? (idx_q == {N{1'b1}}) : (idx_q == {N{1'b0}});
    end

    // last_mode_q only tracks enabled cycles so an en=0 gap does not count
    // as a mode change and the prescaler resumes where it stopped.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            idx_q       <= '0;
            valid_q     <= 1'b0;
            wrap_q      <= 1'b0;
            presc_q     <= '0;
            last_mode_q <= MODE_HOLD;
        end else begin
            wrap_q <= 1'b0;
            if (bus.en) begin
                last_mode_q <= bus.mode;
                case (bus.mode)
                    MODE_HOLD: begin
                        presc_q <= '0;
                    end
                    MODE_LOAD: begin
                        idx_q   <= bus.a;
                        valid_q <= 1'b1;
                        presc_q <= '0;
                    end
                    default: begin
                        if (!valid_q) begin
                            idx_q   <= '0;
                            valid_q <= 1'b1;
                            presc_q <= '0;
                        end else if (bus.mode != last_mode_q) begin
                            presc_q <= '0;
                        end else if (step_due) begin
                            idx_q   <= idx_step;
                            presc_q <= '0;
                            wrap_q  <= at_edge;
                        end else begin
                            presc_q <= presc_q + PW'(1);
                        end
                    end
                endcase
            end
        end
    end

    onehot_dec #(.N(N)) u_dec (
        .sel (idx_q),
        .dec (dec)
    );

    assign bus.out   = (valid_q ? dec : {OUT_W{1'b0}}) ^ POL;
    assign bus.idx   = idx_q;
    assign bus.valid = valid_q;
    assign bus.wrap  = wrap_q;

endmodule

// File: tb/tb_onehot_decoder_seq.sv
// Bench for onehot_decoder_seq: four configurations share one stimulus stream,
// a behavioural model checks every cycle and literal checks pin key points.
module tb_onehot_decoder_seq;
    import onehot_decoder_seq_pkg::*;

    // ---------------- clock / reset / shared stimulus ----------------
    logic       clk = 1'b0;
    logic       rst_n_s = 1'b0;
    logic       en_s = 1'b0;
    mode_t      mode_s = MODE_HOLD;
    logic [2:0] a_s = 3'd0;

    always #5 clk = ~clk;

    onehot_decoder_seq_if #(.N(3)) if0 ();
    onehot_decoder_seq_if #(.N(3)) if1 ();
    onehot_decoder_seq_if #(.N(3)) if2 ();
    onehot_decoder_seq_if #(.N(1)) if3 ();

    assign if0.en = en_s;  assign if0.mode = mode_s;  assign if0.a = a_s;
    assign if1.en = en_s;  assign if1.mode = mode_s;  assign if1.a = a_s;
    assign if2.en = en_s;  assign if2.mode = mode_s;  assign if2.a = a_s;
    assign if3.en = en_s;  assign if3.mode = mode_s;  assign if3.a = a_s[0];

    onehot_decoder_seq #(.N(3), .DIV(4), .ACTIVE_LOW(0)) u0 (.clk(clk), .rst_n(rst_n_s), .bus(if0));
    onehot_decoder_seq #(.N(3), .DIV(2), .ACTIVE_LOW(1)) u1 (.clk(clk), .rst_n(rst_n_s), .bus(if1));
    onehot_decoder_seq #(.N(3), .DIV(1), .ACTIVE_LOW(0)) u2 (.clk(clk), .rst_n(rst_n_s), .bus(if2));
    onehot_decoder_seq #(.N(1), .DIV(1), .ACTIVE_LOW(0)) u3 (.clk(clk), .rst_n(rst_n_s), .bus(if3));

    // ---------------- scoreboard counters ----------------
    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    int    cfg_n   [4] = '{3, 3, 3, 1};
    int    cfg_div [4] = '{4, 2, 1, 1};
    bit    cfg_al  [4] = '{1'b0, 1'b1, 1'b0, 1'b0};
    int    m_idx   [4];
    int    m_cnt   [4];
    bit    m_valid [4];
    bit    m_wrap  [4];
    mode_t m_last  [4];

    always @(posedge clk) begin
        for (int k = 0; k < 4; k++) begin
            int size;
            size = 1 << cfg_n[k];
            if (!rst_n_s) begin
                m_idx[k] = 0; m_cnt[k] = 0; m_valid[k] = 0; m_wrap[k] = 0; m_last[k] = MODE_HOLD;
            end else begin
                m_wrap[k] = 0;
                if (en_s) begin
                    if (mode_s == MODE_HOLD) begin
                        m_cnt[k] = 0;
                    end else if (mode_s == MODE_LOAD) begin
                        m_idx[k] = int'(a_s) % size; m_valid[k] = 1; m_cnt[k] = 0;
                    end else if (!m_valid[k]) begin
                        m_idx[k] = 0; m_valid[k] = 1; m_cnt[k] = 0;
                    end else if (mode_s != m_last[k]) begin
                        m_cnt[k] = 0;
                    end else if (m_cnt[k] == cfg_div[k] - 1) begin
                        m_cnt[k] = 0;
                        if (mode_s == MODE_SCAN_UP) begin
                            m_idx[k]  = (m_idx[k] + 1) % size;
                            m_wrap[k] = (m_idx[k] == 0);
                        end else begin
                            m_idx[k]  = (m_idx[k] + size - 1) % size;
                            m_wrap[k] = (m_idx[k] == size - 1);
                        end
                    end else begin
                        m_cnt[k] = m_cnt[k] + 1;
                    end
                    m_last[k] = mode_s;
                end
            end
        end
    end

    task automatic cmp(input int k, input logic [7:0] out, input logic [7:0] idx,
                       input logic valid, input logic wrap);
        int size, wmask, e;
        size  = 1 << cfg_n[k];
        wmask = ((1 << size) - 1) & 255;
        e     = m_valid[k] ? (1 << m_idx[k]) : 0;
        if (cfg_al[k]) e = e ^ wmask;
        check($sformatf("model d%0d out", k), out, 8'(e));
        check($sformatf("model d%0d idx", k), idx, 8'(m_idx[k]));
        check($sformatf("model d%0d valid", k), {7'd0, valid}, {7'd0, m_valid[k]});
        check($sformatf("model d%0d wrap", k), {7'd0, wrap}, {7'd0, m_wrap[k]});
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            cmp(0, if0.out, 8'(if0.idx), if0.valid, if0.wrap);
            cmp(1, if1.out, 8'(if1.idx), if1.valid, if1.wrap);
            cmp(2, if2.out, 8'(if2.idx), if2.valid, if2.wrap);
            cmp(3, 8'(if3.out), 8'(if3.idx), if3.valid, if3.wrap);
        end
    end

    // ---------------- driver ----------------
    task automatic step(input bit r, input bit e, input mode_t m, input logic [2:0] av);
        rst_n_s = r; en_s = e; mode_s = m; a_s = av;
        @(negedge clk);
    endtask

    // ---------------- directed + random stimulus ----------------
    initial begin
        mode_t cur;
        @(negedge clk);

        // Reset overrides en/LOAD
        step(0, 1, MODE_LOAD, 3'd5);
        chk_en = 1'b1;
        step(0, 1, MODE_LOAD, 3'd5);
        check("reset idx", 8'(if0.idx), 8'h00);
        check("reset valid", {7'd0, if0.valid}, 8'h00);
        check("reset out", if0.out, 8'h00);
        check("reset wrap", {7'd0, if0.wrap}, 8'h00);
        check("reset out active-low", if1.out, 8'hFF);

        // Load latency and hold
        step(1, 1, MODE_LOAD, 3'd5);
        check("load idx", 8'(if0.idx), 8'h05);
        check("load valid", {7'd0, if0.valid}, 8'h01);
        check("load out", if0.out, 8'h20);
        for (int i = 0; i < 10; i++) begin
            step(1, 1, MODE_HOLD, 3'($urandom_range(0, 7)));
            check("hold out", if0.out, 8'h20);
        end

        // Scan up, DIV=4 (d0); first scan cycle is a mode-change idle cycle
        step(1, 1, MODE_LOAD, 3'd6);
        check("scan-up start out", if0.out, 8'h40);
        for (int i = 0; i < 4; i++) step(1, 1, MODE_SCAN_UP, 3'd0);
        check("scan-up before step idx", 8'(if0.idx), 8'h06);
        step(1, 1, MODE_SCAN_UP, 3'd0);
        check("scan-up step idx", 8'(if0.idx), 8'h07);
        check("scan-up step out", if0.out, 8'h80);
        for (int i = 0; i < 3; i++) step(1, 1, MODE_SCAN_UP, 3'd0);
        check("scan-up dwell idx", 8'(if0.idx), 8'h07);
        check("scan-up dwell wrap", {7'd0, if0.wrap}, 8'h00);
        step(1, 1, MODE_SCAN_UP, 3'd0);
        check("scan-up wrap idx", 8'(if0.idx), 8'h00);
        check("scan-up wrap out", if0.out, 8'h01);
        check("scan-up wrap pulse", {7'd0, if0.wrap}, 8'h01);
        step(1, 1, MODE_SCAN_UP, 3'd0);
        check("scan-up wrap clears", {7'd0, if0.wrap}, 8'h00);

        // Scan down with en gaps, DIV=2, active-low (d1)
        step(1, 1, MODE_LOAD, 3'd1);
        check("scan-dn load out", if1.out, 8'hFD);
        step(1, 1, MODE_SCAN_DN, 3'd0);
        step(1, 1, MODE_SCAN_DN, 3'd0);
        for (int i = 0; i < 3; i++) step(1, 0, MODE_SCAN_DN, 3'd0);
        check("scan-dn gap holds idx", 8'(if1.idx), 8'h01);
        step(1, 1, MODE_SCAN_DN, 3'd0);
        check("scan-dn 1->0 idx", 8'(if1.idx), 8'h00);
        check("scan-dn 1->0 out", if1.out, 8'hFE);
        check("scan-dn 1->0 no wrap", {7'd0, if1.wrap}, 8'h00);
        step(1, 1, MODE_SCAN_DN, 3'd0);
        for (int i = 0; i < 3; i++) step(1, 0, MODE_SCAN_DN, 3'd0);
        step(1, 1, MODE_SCAN_DN, 3'd0);
        check("scan-dn 0->7 idx", 8'(if1.idx), 8'h07);
        check("scan-dn 0->7 out", if1.out, 8'h7F);
        check("scan-dn 0->7 wrap", {7'd0, if1.wrap}, 8'h01);
        step(1, 1, MODE_SCAN_DN, 3'd0);
        check("scan-dn wrap clears", {7'd0, if1.wrap}, 8'h00);

        // Scan from invalid plus direction flip, DIV=1 (d2)
        step(0, 1, MODE_HOLD, 3'd0);
        step(1, 1, MODE_SCAN_UP, 3'd0);
        check("invalid-scan idx", 8'(if2.idx), 8'h00);
        check("invalid-scan valid", {7'd0, if2.valid}, 8'h01);
        step(1, 1, MODE_SCAN_UP, 3'd0);
        check("div1 up idx1", 8'(if2.idx), 8'h01);
        step(1, 1, MODE_SCAN_UP, 3'd0);
        check("div1 up idx2", 8'(if2.idx), 8'h02);
        step(1, 1, MODE_SCAN_DN, 3'd0);
        check("flip idle idx", 8'(if2.idx), 8'h02);
        step(1, 1, MODE_SCAN_DN, 3'd0);
        check("div1 dn idx1", 8'(if2.idx), 8'h01);
        step(1, 1, MODE_SCAN_DN, 3'd0);
        check("div1 dn idx0", 8'(if2.idx), 8'h00);
        check("div1 dn idx0 no wrap", {7'd0, if2.wrap}, 8'h00);
        step(1, 1, MODE_SCAN_DN, 3'd0);
        check("div1 dn idx7", 8'(if2.idx), 8'h07);
        check("div1 dn wrap", {7'd0, if2.wrap}, 8'h01);

        // N=1 reset mid-scan (d3)
        step(0, 1, MODE_HOLD, 3'd0);
        step(1, 1, MODE_SCAN_UP, 3'd0);
        step(1, 1, MODE_SCAN_UP, 3'd0);
        check("n1 pre-reset idx", 8'(if3.idx), 8'h01);
        step(0, 1, MODE_SCAN_UP, 3'd0);
        check("n1 reset idx", 8'(if3.idx), 8'h00);
        check("n1 reset valid", {7'd0, if3.valid}, 8'h00);
        check("n1 reset out", 8'(if3.out), 8'h00);
        step(1, 1, MODE_SCAN_UP, 3'd0);
        check("n1 resume out0", 8'(if3.out), 8'h01);
        step(1, 1, MODE_SCAN_UP, 3'd0);
        check("n1 resume out1", 8'(if3.out), 8'h02);
        check("n1 0->1 no wrap", {7'd0, if3.wrap}, 8'h00);
        step(1, 1, MODE_SCAN_UP, 3'd0);
        check("n1 resume out2", 8'(if3.out), 8'h01);
        check("n1 wrap", {7'd0, if3.wrap}, 8'h01);
        step(1, 1, MODE_SCAN_UP, 3'd0);
        step(1, 1, MODE_SCAN_UP, 3'd0);
        check("n1 second wrap", {7'd0, if3.wrap}, 8'h01);

        // Randomised run with sticky modes so scans make progress
        cur = MODE_LOAD;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 15) == 0) cur = mode_t'($urandom_range(0, 3));
            step($urandom_range(0, 199) != 0, $urandom_range(0, 5) != 0, cur,
                 3'($urandom_range(0, 7)));
        end

        chk_en = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
